nios_led_out: RTL and testbench

Avalon-MM slave output port: the write-side counterpart of the Nios input PIO. It drives a parallel output bus (LEDs, enables) from the Nios CPU through four word-addressed registers. Besides static data and atomic toggle, a hardware one-shot pulse overlay inverts selected bits for a programmed number of clocks without CPU timing.

---
 rtl/nios_led_out.sv | 139 +++++++++++++
 tb/tb_nios_led_out.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/nios_led_out.sv
// rtl/nios_led_out.sv - Avalon-MM output port with toggle and one-shot pulse overlay
//
// Drives a parallel output bus from four word-addressed registers:
//   0 DATA      static output value (R/W)
//   1 PULSE_LEN pulse length in clocks, 16 bits (R/W)
//   2 PULSE     write starts/restarts a pulse with the given mask;
//               read returns {busy, CNT}
//   3 TOGGLE    write XORs writedata into DATA; reads as 0
// While a pulse runs, out_port = DATA ^ MASK; otherwise out_port = DATA.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   registered read data, one clock after the address
//   out_port   registered output bus

module nios_led_out #(
   parameter int          WIDTH       = 8,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

   typedef enum logic {
      IDLE    = 1'b0,
      PULSING = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [15:0]      pulse_len_q, pulse_len_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] out_d;
   logic [31:0]      rd_d;
   logic [31:0]      data_ext;
   logic             busy_q;
   logic             wr_en;
   logic             pulse_wr;
   logic [WIDTH-1:0] wdata_w;

   // Only the low WIDTH (or 16) bits of writedata carry information.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   assign wr_en    = chipselect & ~write_n;
   assign wdata_w  = writedata[WIDTH-1:0];
   // A PULSE write with a zero length is dropped entirely.
   assign pulse_wr = wr_en && (address == 2'd2) && (pulse_len_q != 16'd0);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         data_q      <= RST_DATA;
         mask_q      <= '0;
         pulse_len_q <= 16'd0;
         cnt_q       <= 16'd0;
         out_port    <= RST_DATA;
         readdata    <= 32'd0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
         pulse_len_q <= pulse_len_d;
         cnt_q       <= cnt_d;
         out_port    <= out_d;
         readdata    <= rd_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      mask_d      = mask_q;
      pulse_len_d = pulse_len_q;
      cnt_d       = cnt_q;

      if (wr_en) begin
         case (address)
            2'd0:    data_d      = wdata_w;
            2'd1:    pulse_len_d = writedata[15:0];
            2'd3:    data_d      = data_q ^ wdata_w;
            default: ;
         endcase
      end

      // A new pulse (or restart) takes priority over countdown/expiry,
      // so a restart never passes through IDLE.
      if (pulse_wr) begin
         state_d = PULSING;
         mask_d  = wdata_w;
         cnt_d   = pulse_len_q;
      end else if (state_q == PULSING) begin
         if (cnt_q == 16'd1) begin
            state_d = IDLE;
            mask_d  = '0;
            cnt_d   = 16'd0;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end
   end

   // Output logic
   always_comb begin
      busy_q = (state_q == PULSING);

      // out_port is loaded from next-state values so writes and pulse
      // edges appear right after the edge that samples them.
      out_d = data_d ^ ((state_d == PULSING) ? mask_d : '0);

      data_ext              = 32'd0;
      data_ext[WIDTH-1:0]   = data_q;

      // Reads see pre-edge register values: read-during-write returns old data.
      case (address)
         2'd0:    rd_d = data_ext;
         2'd1:    rd_d = {16'd0, pulse_len_q};
         2'd2:    rd_d = {15'd0, busy_q, cnt_q};
         default: rd_d = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_nios_led_out.sv
// tb/tb_nios_led_out.sv - scoreboard testbench for nios_led_out

module tb_nios_led_out;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   typedef struct {
      string       name;
      logic [7:0]  exp_out;
      bit          chk_rd;
      logic [31:0] exp_rd;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   nios_led_out #(.WIDTH(8), .RESET_VALUE(32'h0000_00A5)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   // Monitor: after every clock edge or reset assertion, pop and compare.
   always @(posedge clk or negedge reset_n) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec++;
         if (out_port !== e.exp_out) begin
            n_fail++;
            $display("FAIL %s out_port: got %h expected %h", e.name, out_port, e.exp_out);
         end
         if (e.chk_rd) begin
            n_vec++;
            if (readdata !== e.exp_rd) begin
               n_fail++;
               $display("FAIL %s readdata: got %h expected %h", e.name, readdata, e.exp_rd);
            end
         end
      end
   end

   // One clock with the given bus cycle; called at a falling edge.
   task automatic step(input logic [1:0] a, input logic cs, input logic wr,
                       input logic [31:0] wd, input string nm,
                       input logic [7:0] eo, input bit crd, input logic [31:0] erd);
      exp_t e;
      address    = a;
      chipselect = cs;
      write_n    = ~wr;
      writedata  = wd;
      e.name = nm; e.exp_out = eo; e.chk_rd = crd; e.exp_rd = erd;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] wd, input string nm,
                     input logic [7:0] eo, input bit crd, input logic [31:0] erd);
      step(a, 1'b1, 1'b1, wd, nm, eo, crd, erd);
   endtask

   task automatic rd(input logic [1:0] a, input string nm,
                     input logic [7:0] eo, input bit crd, input logic [31:0] erd);
      step(a, 1'b1, 1'b0, 32'd0, nm, eo, crd, erd);
   endtask

   initial begin
      exp_t e;
      int   wait_cnt;

      // Reset state
      @(negedge clk);
      step(2'd0, 1'b0, 1'b0, 32'd0, "reset", 8'hA5, 1'b1, 32'd0);
      reset_n = 1'b1;

      rd(2'd0, "rd_data_rst", 8'hA5, 1'b1, 32'h0000_00A5);

      // DATA write (upper bits ignored, read-during-write returns old) then TOGGLE
      wr(2'd0, 32'hFFFF_FF3C, "wr_data",  8'h3C, 1'b1, 32'h0000_00A5);
      wr(2'd3, 32'h0000_000F, "toggle",   8'h33, 1'b1, 32'd0);
      rd(2'd3, "rd_toggle",               8'h33, 1'b1, 32'd0);
      rd(2'd0, "rd_data",                 8'h33, 1'b1, 32'h0000_0033);

      // Pulse of length 3
      wr(2'd1, 32'd3,  "wr_len3",  8'h33, 1'b1, 32'd0);
      wr(2'd0, 32'd0,  "wr_data0", 8'h00, 1'b1, 32'h0000_0033);
      wr(2'd2, 32'h81, "pulse_n",  8'h81, 1'b1, 32'd0);
      rd(2'd2, "pulse_n1", 8'h81, 1'b1, 32'h0001_0003);
      rd(2'd2, "pulse_n2", 8'h81, 1'b1, 32'h0001_0002);
      rd(2'd2, "pulse_n3", 8'h00, 1'b1, 32'h0001_0001);
      rd(2'd2, "pulse_idle", 8'h00, 1'b1, 32'd0);

      // Restart: len 4, mask 01, then mask 02 two clocks later
      wr(2'd1, 32'd4,  "wr_len4",   8'h00, 1'b1, 32'd3);
      wr(2'd2, 32'h01, "rst_p1",    8'h01, 1'b0, 32'd0);
      rd(2'd2, "rst_p1b",           8'h01, 1'b1, 32'h0001_0004);
      wr(2'd2, 32'h02, "rst_p2",    8'h02, 1'b1, 32'h0001_0003);
      rd(2'd2, "rst_c3",            8'h02, 1'b1, 32'h0001_0004);
      rd(2'd2, "rst_c2",            8'h02, 1'b1, 32'h0001_0003);
      rd(2'd2, "rst_c1",            8'h02, 1'b1, 32'h0001_0002);
      rd(2'd2, "rst_end",           8'h00, 1'b1, 32'h0001_0001);
      rd(2'd2, "rst_idle",          8'h00, 1'b1, 32'd0);

      // DATA write during pulse, then DATA write on the expiry edge
      wr(2'd0, 32'h55, "wr_data55", 8'h55, 1'b0, 32'd0);
      wr(2'd1, 32'd2,  "wr_len2",   8'h55, 1'b0, 32'd0);
      wr(2'd2, 32'h0F, "p2_start",  8'h5A, 1'b0, 32'd0);
      wr(2'd0, 32'hF0, "p2_datawr", 8'hFF, 1'b0, 32'd0);
      wr(2'd0, 32'h55, "p2_expiry", 8'h55, 1'b1, 32'h0000_00F0);

      // Zero mask: busy visible, out_port unchanged
      wr(2'd2, 32'h00, "m0_start", 8'h55, 1'b0, 32'd0);
      rd(2'd2, "m0_busy",          8'h55, 1'b1, 32'h0001_0002);
      wr(2'd1, 32'd0,  "wr_len0",  8'h55, 1'b1, 32'd2);

      // PULSE_LEN = 0: pulse write ignored
      wr(2'd2, 32'hFF, "len0_pulse", 8'h55, 1'b1, 32'd0);
      rd(2'd2, "len0_idle",          8'h55, 1'b1, 32'd0);

      // chipselect = 0 writes have no effect
      step(2'd0, 1'b0, 1'b1, 32'h00,  "cs0_data",   8'h55, 1'b0, 32'd0);
      step(2'd3, 1'b0, 1'b1, 32'hFF,  "cs0_toggle", 8'h55, 1'b0, 32'd0);
      step(2'd1, 1'b0, 1'b1, 32'h07,  "cs0_len",    8'h55, 1'b0, 32'd0);
      rd(2'd1, "cs0_rd_len",          8'h55, 1'b1, 32'd0);

      // Reset mid-pulse
      wr(2'd3, 32'hFF, "toggle_ff", 8'hAA, 1'b0, 32'd0);
      wr(2'd1, 32'd10, "wr_len10",  8'hAA, 1'b0, 32'd0);
      wr(2'd2, 32'hF0, "p10_start", 8'h5A, 1'b0, 32'd0);
      rd(2'd2, "p10_run",           8'h5A, 1'b1, 32'h0001_000A);
      e.name = "async_reset"; e.exp_out = 8'hA5; e.chk_rd = 1'b1; e.exp_rd = 32'd0;
      sb.push_back(e);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      rd(2'd2, "post_rst_busy", 8'hA5, 1'b1, 32'd0);
      rd(2'd1, "post_rst_len",  8'hA5, 1'b1, 32'd0);
      rd(2'd0, "post_rst_data", 8'hA5, 1'b1, 32'h0000_00A5);

      // Drain scoreboard with a bound
      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (sb.size() > 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
